matrix_proc_ctrl_param: RTL and testbench
=========================================

// Module: matrix_proc_ctrl_param
// PURPOSE
//  Parametrised sequencer for the matrix processor datapath. Loads a DIM x DIM matrix
//  once, then loops over wi_count work items. Each work item loads VEC_BATCH vectors
//  and runs VEC_BATCH*DIM FMA row passes. Memory loads stall on rd_valid. Owns the
//  work-item counter and reports busy/done to the dispatcher.
// PARAMETERS
//  DIM        4   matrix dimension; power of two, >=2
//  VEC_BATCH  4   vectors per work item; power of two, 1..DIM
//  WI_W       16  width of work-item count
//  (local) CW = $clog2(DIM*DIM)  index counter width
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     synchronous active-low reset
//  start         in   1     begin job; sampled only in IDLE
//  wi_count      in   WI_W  work items for job; latched on accepted start
//  rd_valid      in   1     load data valid this cycle
//  busy          out  1     state != IDLE
//  done          out  1     1-cycle pulse, job complete
//  idx           out  CW    element/vector/row index to datapath
//  wi_init       out  1     accepted start (load address generators)
//  wi_next       out  1     pulse, last PROC cycle of a work item
//  load_matrix   out  1     write matrix element idx
//  load_vector   out  1     write vector idx
//  read_addr_src out  1     1 = vector address source, 0 = matrix
//  en_fma        out  1     FMA enable
//  write_en      out  1     result row write
// BEHAVIOUR
//  - Reset is clk and rst_n, synchronous, active-low. While rst_n=0, all outputs are
//    forced 0 combinationally. At the next edge: state=IDLE, idx=0, remaining=0, done=0.
//  - IDLE: start && wi_count!=0 -> wi_init=1, remaining<=wi_count, idx<=0, ->LOAD_M.
//    start && wi_count==0 -> stay IDLE, done=1 next cycle.
//  - LOAD_M: load_matrix=rd_valid, read_addr_src=0. idx++ only when rd_valid.
//    idx==DIM*DIM-1 && rd_valid -> idx<=0, ->LOAD_V. rd_valid=0 holds all state.
//  - LOAD_V: load_vector=rd_valid, read_addr_src=1. idx++ on rd_valid.
//    idx==VEC_BATCH-1 && rd_valid -> idx<=0, ->PROC.
//  - PROC: en_fma=1 every cycle, never stalls. idx runs 0..VEC_BATCH*DIM-1.
//    write_en=1 when idx[log2(DIM)-1:0]==DIM-1.
//    At the last idx: wi_next=1, remaining--, idx<=0.
//    If remaining==1: ->IDLE, done=1 next cycle. Else: ->LOAD_V (matrix kept).
//  - Job latency with rd_valid=1 and N items: 1 + DIM*DIM + N*(VEC_BATCH+VEC_BATCH*DIM)
//    cycles from the start edge to done.
//  - start while busy is ignored; wi_count changes while busy are ignored.
//  - idx wraps only via explicit clear, never by overflow. Unused idx bits read 0.
//  - done is registered, high exactly one cycle, while busy=0.
//  - Illegal state encoding -> IDLE next edge, all outputs 0.
// CONFIGURATION
//  MATPROC_STALL_CNT_EN defined:
//    - adds output stall_cnt[15:0].
//    - stall_cnt counts LOAD_M/LOAD_V cycles with rd_valid=0.
//    - cleared on wi_init and on reset; saturates at 16'hFFFF; holds after done.
//  MATPROC_STALL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (DIM=4, VEC_BATCH=4)
//  1. wi_count=1, rd_valid=1 -> 16 load_matrix (idx 0..15), 4 load_vector, 16 en_fma,
//     write_en at idx 3,7,11,15; done 37 cycles after start edge.
//  2. wi_count=3, rd_valid=1 -> load_matrix 16 total; 3 wi_next pulses; 12 write_en;
//     done once, at cycle 1+16+3*20=77.
//  3. rd_valid alternating 0/1 in LOAD_M -> idx holds on 0 cycles; 16 load_matrix
//     over 32 cycles; with macro, stall_cnt=16 after LOAD_M.
//  4. start with wi_count=0 -> no load/fma; done=1 next cycle; busy stays 0.
//  5. rst_n=0 mid-PROC (idx=7) -> all outputs 0 that cycle; IDLE, idx=0 after edge.
//     Next start replays test 1 timing exactly.
//  6. start pulsed with wi_count=9 during LOAD_V of a wi_count=2 job -> ignored;
//     exactly 2 wi_next, single done.

Source files
------------

// File: rtl/matrix_proc_ctrl_param.sv
// Sequencer for the matrix processor: loads a DIM x DIM matrix once, then per work item
// loads VEC_BATCH vectors and runs VEC_BATCH*DIM FMA row passes. Optional stall counter: MATPROC_STALL_CNT_EN.
module matrix_proc_ctrl_param #(
  parameter int unsigned DIM       = 4,
  parameter int unsigned VEC_BATCH = 4,
  parameter int unsigned WI_W      = 16,
  localparam int unsigned CW       = $clog2(DIM*DIM)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [WI_W-1:0] wi_count,
  input  logic            rd_valid,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   idx,
  output logic            wi_init,
  output logic            wi_next,
  output logic            load_matrix,
  output logic            load_vector,
  output logic            read_addr_src,
  output logic            en_fma,
  output logic            write_en
`ifdef MATPROC_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int unsigned LOG_DIM = $clog2(DIM);
  localparam logic [CW-1:0]      M_LAST   = CW'(DIM*DIM - 1);
  localparam logic [CW-1:0]      V_LAST   = CW'(VEC_BATCH - 1);
  localparam logic [CW-1:0]      P_LAST   = CW'(VEC_BATCH*DIM - 1);
  localparam logic [LOG_DIM-1:0] ROW_LAST = LOG_DIM'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_M = 2'd1,
    S_LOAD_V = 2'd2,
    S_PROC   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [WI_W-1:0] rem_q, rem_d;
  logic            done_q, done_d;
  logic            accept;

  assign accept = (state_q == S_IDLE) && start && (wi_count != '0);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (wi_count != '0) begin
            rem_d   = wi_count;
            idx_d   = '0;
            state_d = S_LOAD_M;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_LOAD_M: begin
        if (rd_valid) begin
          if (idx_q == M_LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_V;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LOAD_V: begin
        if (rd_valid) begin
          if (idx_q == V_LAST) begin
            idx_d   = '0;
            state_d = S_PROC;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PROC: begin
        if (idx_q == P_LAST) begin
          idx_d = '0;
          rem_d = rem_q - 1'b1;
          // Matrix stays resident; only vectors are reloaded for the next item.
          if (rem_q == WI_W'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD_V;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  // Every output is gated by rst_n so the datapath sees nothing during reset.
  always_comb begin
    busy          = rst_n && (state_q != S_IDLE);
    done          = rst_n && done_q;
    idx           = rst_n ? idx_q : '0;
    wi_init       = rst_n && accept;
    wi_next       = rst_n && (state_q == S_PROC) && (idx_q == P_LAST);
    load_matrix   = rst_n && (state_q == S_LOAD_M) && rd_valid;
    load_vector   = rst_n && (state_q == S_LOAD_V) && rd_valid;
    read_addr_src = rst_n && (state_q == S_LOAD_V);
    en_fma        = rst_n && (state_q == S_PROC);
    write_en      = rst_n && (state_q == S_PROC) && (idx_q[LOG_DIM-1:0] == ROW_LAST);
  end

`ifdef MATPROC_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (((state_q == S_LOAD_M) || (state_q == S_LOAD_V)) && !rd_valid
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = rst_n ? stall_q : '0;
`endif

endmodule

// File: tb/tb_matrix_proc_ctrl_param.sv
// Scoreboard bench for matrix_proc_ctrl_param (DIM=4, VEC_BATCH=4): a timeline model
// of load beats and FMA passes feeds an event queue that a negedge monitor drains.
module tb_matrix_proc_ctrl_param;
  localparam int DIM   = 4;
  localparam int VB    = 4;
  localparam int WI_W  = 16;
  localparam int CW    = 4;
  localparam int PAT_N = 1024;

  localparam int K_LM   = 0;
  localparam int K_LV   = 1;
  localparam int K_FMA  = 2;
  localparam int K_WE   = 3;
  localparam int K_WN   = 4;
  localparam int K_DONE = 5;

  logic            clk = 1'b0;
  logic            rst_n, start, rd_valid;
  logic [WI_W-1:0] wi_count;
  logic            busy, done, wi_init, wi_next, load_matrix, load_vector;
  logic            read_addr_src, en_fma, write_en;
  logic [CW-1:0]   idx;
`ifdef MATPROC_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  matrix_proc_ctrl_param #(.DIM(DIM), .VEC_BATCH(VB), .WI_W(WI_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wi_count(wi_count), .rd_valid(rd_valid),
    .busy(busy), .done(done), .idx(idx), .wi_init(wi_init), .wi_next(wi_next),
    .load_matrix(load_matrix), .load_vector(load_vector), .read_addr_src(read_addr_src),
    .en_fma(en_fma), .write_en(write_en)
`ifdef MATPROC_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int idx; int aux; int t; } ev_t;
  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  bit pat[PAT_N];
  int launch = 0;

  function automatic bit rv_at(int k);
    return (k >= 1 && k < PAT_N) ? pat[k] : 1'b1;
  endfunction

  // rd_valid follows the pattern indexed by cycles since the start launch.
  initial begin
    rd_valid = 1'b1;
    forever begin
      @(posedge clk); #1;
      rd_valid = rv_at(cyc - launch);
    end
  end

  task automatic chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, req);
    end
  endtask

  task automatic pop_check(int kind, int idx_v, int aux_v, string name);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected at cycle %0d (idx=%0d), no event required", name, cyc, idx_v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.idx != idx_v || e.aux != aux_v || e.t != cyc) begin
        errors++;
        $display("FAIL %s: got kind=%0d idx=%0d aux=%0d cycle=%0d, required kind=%0d idx=%0d aux=%0d cycle=%0d",
                 name, kind, idx_v, aux_v, cyc, e.kind, e.idx, e.aux, e.t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (load_matrix) pop_check(K_LM, int'(idx), int'(read_addr_src), "load_matrix");
      if (load_vector) pop_check(K_LV, int'(idx), int'(read_addr_src), "load_vector");
      if (en_fma)      pop_check(K_FMA, int'(idx), int'(busy), "en_fma");
      if (write_en)    pop_check(K_WE, int'(idx), int'(en_fma), "write_en");
      if (wi_next)     pop_check(K_WN, int'(idx), int'(en_fma), "wi_next");
      if (done)        pop_check(K_DONE, int'(idx), int'(busy), "done");
    end
  end

  task automatic set_pat(int mode);
    for (int k = 0; k < PAT_N; k++) begin
      case (mode)
        1:       pat[k] = (k > 32) || (k % 2 == 0);
        2:       pat[k] = ($urandom_range(0, 3) != 0);
        default: pat[k] = 1'b1;
      endcase
    end
  endtask

  // Timeline model: each load beat takes the next cycle with rd_valid high, each
  // FMA pass takes exactly one cycle, done appears the cycle after the last pass.
  task automatic model_job(int n, int L, output int stalls);
    int t;
    t = L + 1;
    stalls = 0;
    if (n == 0) begin
      exp_q.push_back('{K_DONE, 0, 0, L + 1});
      return;
    end
    for (int i = 0; i < DIM*DIM; i++) begin
      while (!rv_at(t - L)) begin t++; stalls++; end
      exp_q.push_back('{K_LM, i, 0, t});
      t++;
    end
    for (int w = 0; w < n; w++) begin
      for (int j = 0; j < VB; j++) begin
        while (!rv_at(t - L)) begin t++; stalls++; end
        exp_q.push_back('{K_LV, j, 1, t});
        t++;
      end
      for (int p = 0; p < VB*DIM; p++) begin
        exp_q.push_back('{K_FMA, p, 1, t});
        if (p % DIM == DIM - 1) exp_q.push_back('{K_WE, p, 1, t});
        if (p == VB*DIM - 1)    exp_q.push_back('{K_WN, p, 1, t});
        t++;
      end
    end
    exp_q.push_back('{K_DONE, 0, 0, t});
  endtask

  function automatic int outs_all();
    logic [CW+8:0] ov;
    ov = {busy, done, idx, wi_init, wi_next, load_matrix, load_vector,
          read_addr_src, en_fma, write_en};
    return int'(ov);
  endfunction

  task automatic run_job(int n, int mode, int inj_k, int inj_cnt, int rst_k);
    int stalls;
    int L;
    bit aborted;
    aborted = 1'b0;
    set_pat(mode);
    @(posedge clk); #1;
    L = cyc;
    launch = cyc;
    model_job(n, L, stalls);
    start = 1'b1;
    wi_count = WI_W'(n);
    #1 chk("wi_init_on_start", int'(wi_init), (n != 0) ? 1 : 0);
    @(posedge clk); #1;
    start = 1'b0;
    wi_count = WI_W'($urandom);
    if (n == 0) chk("zero_job_busy", int'(busy), 0);
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (inj_k > 0 && cyc == L + inj_k) begin
        start = 1'b1;
        wi_count = WI_W'(inj_cnt);
        #1 chk("start_while_busy_ignored", int'({busy, wi_init}), 2);
      end
      if (rst_k > 0 && cyc == L + rst_k) begin
        chk("pre_reset_idx", int'(idx), 7);
        rst_n = 1'b0;
        #1 chk("outputs_in_reset", outs_all(), 0);
        exp_q.delete();
        aborted = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("after_reset_busy_idx_done", int'({busy, done, idx}), 0);
      end
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL job_timeout: %0d events still pending, required 0", exp_q.size());
      exp_q.delete();
    end
`ifdef MATPROC_STALL_CNT_EN
    if (!aborted && n != 0) chk("stall_cnt", int'(stall_cnt), stalls);
`endif
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    wi_count = WI_W'(5);
    set_pat(0);
    repeat (3) @(posedge clk);
    #1 chk("outputs_in_reset", outs_all(), 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 chk("reset_state", int'({busy, done, idx}), 0);

    run_job(1, 0, 0, 0, 0);    // done 37 cycles after launch
    run_job(3, 0, 0, 0, 0);    // done at 77, three wi_next
    run_job(1, 1, 0, 0, 0);    // alternating rd_valid during matrix load
    run_job(0, 0, 0, 0, 0);    // zero items: done only
    run_job(1, 0, 0, 0, 28);   // reset at PROC idx 7
    run_job(1, 0, 0, 0, 0);    // replay after reset
    run_job(2, 0, 18, 9, 0);   // start during LOAD_V ignored

    for (int r = 0; r < 10; r++) begin
      run_job($urandom_range(0, 4), 2, $urandom_range(2, 30), $urandom_range(0, 65535), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
